// File: rtl/uart_pkg.sv
// Shared types and default parameters for the 8N1 UART.
// Imported by the FIFO and by the top level.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_DBIT    = 8;
    localparam int UART_SB_TICK = 16;
    localparam int UART_FIFO_W  = 2;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with show-ahead read data.
// Writes when full and reads when empty are ignored.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DW = UART_DBIT,
    parameter int AW = UART_FIFO_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr,
    input  logic          i_rd,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_empty,
    output logic          o_full
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_do_rd;
    logic          w_do_wr;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_rdata = r_mem[r_rptr];

    // A full FIFO still takes a write when a read frees a slot this cycle.
    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_do_wr && !w_do_rd) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_do_rd && !w_do_wr) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/top_uart.sv
// Full-duplex 8N1 UART: programmable baud tick, 16x oversampled RX,
// TX, and a small FIFO in each direction.
module top_uart
    import uart_pkg::*;
#(
    parameter int DBIT    = UART_DBIT,
    parameter int SB_TICK = UART_SB_TICK,
    parameter int FIFO_W  = UART_FIFO_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [10:0]     TIMER_FINAL_VALUE,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    input  logic [DBIT-1:0] w_data,
    input  logic            wr_uart,
    output logic            tx_full,
    output logic            tx
);

    logic [10:0]     r_tmr;
    logic            w_tick;

    uart_state_t     r_rx_state;
    logic [3:0]      r_rx_s;
    logic [2:0]      r_rx_n;
    logic [DBIT-1:0] r_rx_b;
    logic            r_rx_done;
    logic            w_rx_full;

    uart_state_t     r_tx_state;
    logic [3:0]      r_tx_s;
    logic [2:0]      r_tx_n;
    logic [DBIT-1:0] r_tx_b;
    logic            r_tx;
    logic            w_tx_empty;
    logic [DBIT-1:0] w_tx_head;
    logic            w_tx_pop;
    logic            w_tx_stop_end;

    assign w_tick = (r_tmr == TIMER_FINAL_VALUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= w_tick ? 11'd0 : r_tmr + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= IDLE;
            r_rx_s     <= '0;
            r_rx_n     <= '0;
            r_rx_b     <= '0;
            r_rx_done  <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            unique case (r_rx_state)
                IDLE: begin
                    if (!rx) begin
                        r_rx_state <= START;
                        r_rx_s     <= '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_rx_s == 4'd7) begin
                            r_rx_state <= DATA;
                            r_rx_s     <= '0;
                            r_rx_n     <= '0;
                        end else begin
                            r_rx_s <= r_rx_s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_rx_s == 4'd15) begin
                            r_rx_s <= '0;
                            r_rx_b <= {rx, r_rx_b[DBIT-1:1]};
                            if (r_rx_n == 3'(DBIT - 1)) begin
                                r_rx_state <= STOP;
                            end else begin
                                r_rx_n <= r_rx_n + 3'd1;
                            end
                        end else begin
                            r_rx_s <= r_rx_s + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_rx_s == 4'(SB_TICK - 1)) begin
                            r_rx_state <= IDLE;
                            r_rx_s     <= '0;
                            r_rx_done  <= 1'b1;
                        end else begin
                            r_rx_s <= r_rx_s + 4'd1;
                        end
                    end
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

    // A pending byte is taken straight from the stop bit, leaving no idle gap.
    assign w_tx_stop_end = (r_tx_state == STOP) && w_tick &&
                           (r_tx_s == 4'(SB_TICK - 1));
    assign w_tx_pop      = !w_tx_empty &&
                           ((r_tx_state == IDLE) || w_tx_stop_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= IDLE;
            r_tx_s     <= '0;
            r_tx_n     <= '0;
            r_tx_b     <= '0;
            r_tx       <= 1'b1;
        end else begin
            unique case (r_tx_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_tx_empty) begin
                        r_tx_state <= START;
                        r_tx_s     <= '0;
                        r_tx_b     <= w_tx_head;
                        r_tx       <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_tx_s == 4'd15) begin
                            r_tx_state <= DATA;
                            r_tx_s     <= '0;
                            r_tx_n     <= '0;
                            r_tx       <= r_tx_b[0];
                        end else begin
                            r_tx_s <= r_tx_s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_tx_s == 4'd15) begin
                            r_tx_s <= '0;
                            r_tx_b <= {1'b0, r_tx_b[DBIT-1:1]};
                            if (r_tx_n == 3'(DBIT - 1)) begin
                                r_tx_state <= STOP;
                                r_tx       <= 1'b1;
                            end else begin
                                r_tx_n <= r_tx_n + 3'd1;
                                r_tx   <= r_tx_b[1];
                            end
                        end else begin
                            r_tx_s <= r_tx_s + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (w_tx_stop_end && !w_tx_empty) begin
                            r_tx_state <= START;
                            r_tx_s     <= '0;
                            r_tx_b     <= w_tx_head;
                            r_tx       <= 1'b0;
                        end else if (w_tx_stop_end) begin
                            r_tx_state <= IDLE;
                            r_tx_s     <= '0;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_s <= r_tx_s + 4'd1;
                        end
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

    assign tx = r_tx;

    uart_fifo #(
        .DW (DBIT),
        .AW (FIFO_W)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (r_rx_done && !w_rx_full),
        .i_rd    (rd_uart),
        .i_wdata (r_rx_b),
        .o_rdata (r_data),
        .o_empty (rx_empty),
        .o_full  (w_rx_full)
    );

    uart_fifo #(
        .DW (DBIT),
        .AW (FIFO_W)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (wr_uart),
        .i_rd    (w_tx_pop),
        .i_wdata (w_data),
        .o_rdata (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (tx_full)
    );

endmodule

// File: tb/tb_top_uart.sv
// Directed bench for top_uart with a TX frame monitor and
// scoreboard queues for both directions.
module tb_top_uart;

    logic        clk;
    logic        rst;
    logic [10:0] tfv;
    logic        r_loop;
    logic        r_rxd;
    logic        w_rx;
    logic        rd_uart;
    logic [7:0]  r_data;
    logic        rx_empty;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic        tx_full;
    logic        tx;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];

    int          m_per;
    logic [7:0]  m_b;
    logic [7:0]  m_e;

    assign w_rx = r_loop ? tx : r_rxd;

    top_uart dut (
        .clk               (clk),
        .rst               (rst),
        .TIMER_FINAL_VALUE (tfv),
        .rx                (w_rx),
        .rd_uart           (rd_uart),
        .r_data            (r_data),
        .rx_empty          (rx_empty),
        .w_data            (w_data),
        .wr_uart           (wr_uart),
        .tx_full           (tx_full),
        .tx                (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_tx(input logic [7:0] v);
        w_data  = v;
        wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic wait_rx(input int maxc);
        for (int i = 0; i < maxc && rx_empty; i++) @(negedge clk);
        chk("rx_arrive", rx_empty, 1'b0);
    endtask

    task automatic drain_rx();
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            if (!rx_empty) begin
                e = (rxq.size() != 0) ? rxq.pop_front() : 8'hxx;
                chk("rx_data", r_data, e);
                rd_uart = 1'b1;
                @(negedge clk);
                rd_uart = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("rx_drained", rx_empty, 1'b1);
    endtask

    task automatic send_rx(input logic [7:0] v, input int per);
        r_rxd = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            r_rxd = v[i];
            repeat (per) @(negedge clk);
        end
        r_rxd = 1'b1;
        repeat (per) @(negedge clk);
    endtask

    // Lowering the divisor may force a full counter wrap before ticks resume.
    task automatic set_tfv(input logic [10:0] v);
        tfv = v;
        repeat (2100) @(negedge clk);
    endtask

    task automatic wait_txq(input int maxc);
        for (int i = 0; i < maxc && txq.size() != 0; i++) @(negedge clk);
        chk("txq_drain", txq.size(), 0);
    endtask

    // TX monitor: mid-bit sampling, compares each frame against txq.
    always begin
        @(negedge clk);
        if (mon_en && rst && tx === 1'b0) begin
            m_per = 16 * (int'(tfv) + 1);
            repeat (m_per / 2) @(negedge clk);
            chk("mon_start", tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (m_per) @(negedge clk);
                m_b[i] = tx;
            end
            repeat (m_per) @(negedge clk);
            chk("mon_stop", tx, 1'b1);
            m_e = (txq.size() != 0) ? txq.pop_front() : 8'hxx;
            chk("mon_byte", m_b, m_e);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        int         mcnt;
        int         t0;
        logic       last;

        rst     = 1'b0;
        tfv     = 11'd0;
        r_loop  = 1'b0;
        r_rxd   = 1'b1;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        w_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_tx_full", tx_full, 1'b0);
        chk("rst_r_data", r_data, 8'h00);
        mon_en = 1'b1;

        // Exact TX frame at one tick per clock.
        txq.push_back(8'h0F);
        write_tx(8'h0F);
        chk("tx_lat_idle", tx, 1'b1);
        @(negedge clk);
        pat = {1'b1, 8'h0F, 1'b0};
        for (int o = 0; o < 160; o++) begin
            if ((o % 16) == 0 || (o % 16) == 15)
                chk("tx_frame", tx, pat[o/16]);
            @(negedge clk);
        end
        chk("tx_frame_end", tx, 1'b1);
        repeat (20) @(negedge clk);

        // Loopback at divisor 3.
        tfv    = 11'd3;
        r_loop = 1'b1;
        repeat (10) @(negedge clk);
        txq.push_back(8'hA5);
        rxq.push_back(8'hA5);
        write_tx(8'hA5);
        wait_rx(2000);
        drain_rx();
        txq.push_back(8'h3C);
        write_tx(8'h3C);
        wait_rx(2000);
        chk("rx_keep", r_data, 8'h3C);
        repeat (100) @(negedge clk);

        // Reset in the middle of a TX frame.
        mon_en = 1'b0;
        r_loop = 1'b0;
        write_tx(8'h99);
        repeat (150) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_rx_empty", rx_empty, 1'b1);
        chk("mid_rst_tx_full", tx_full, 1'b0);
        chk("mid_rst_r_data", r_data, 8'h00);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        repeat (200) @(negedge clk);
        chk("post_rst_tx", tx, 1'b1);

        // TX FIFO full while a frame is in flight.
        set_tfv(11'd0);
        txq.push_back(8'h11);
        write_tx(8'h11);
        repeat (3) @(negedge clk);
        mcnt = 0;
        for (int i = 0; i < 5; i++) begin
            w_data  = 8'(8'h22 + 8'h11 * i);
            wr_uart = 1'b1;
            if (mcnt < 4) begin
                txq.push_back(w_data);
                mcnt++;
            end
            @(negedge clk);
        end
        wr_uart = 1'b0;
        chk("tx_full_set", tx_full, 1'b1);
        write_tx(8'h77);
        chk("tx_full_hold", tx_full, 1'b1);
        wait_txq(1500);
        chk("tx_full_clr", tx_full, 1'b0);
        repeat (200) @(negedge clk);

        // Divisor 9: every data bit lasts 160 clocks.
        tfv = 11'd9;
        txq.push_back(8'h55);
        write_tx(8'h55);
        for (int i = 0; i < 50 && tx !== 1'b0; i++) @(negedge clk);
        for (int i = 0; i < 400 && tx !== 1'b1; i++) @(negedge clk);
        t0   = cyc;
        last = tx;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 400 && tx === last; i++) @(negedge clk);
            chk("bit_len", cyc - t0, 160);
            t0   = cyc;
            last = tx;
        end
        wait_txq(2000);

        // Idle line, read-when-empty, then directly driven RX frames.
        set_tfv(11'd3);
        chk("rx_idle_empty", rx_empty, 1'b1);
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
        chk("rd_empty_flag", rx_empty, 1'b1);
        chk("rd_empty_data", r_data, 8'h00);
        rxq.push_back(8'h00);
        send_rx(8'h00, 64);
        chk("rx_zero_arrive", rx_empty, 1'b0);
        rxq.push_back(8'hC3);
        send_rx(8'hC3, 64);
        repeat (20) @(negedge clk);
        drain_rx();

        chk("txq_empty_end", txq.size(), 0);
        chk("rxq_empty_end", rxq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/top_uart.md
# top_uart

Full-duplex 8N1 UART with a runtime-programmable baud tick, a 16× oversampling receiver, a transmitter, and a small FIFO on each direction. It is the serial front end between the microwave controller logic and the external serial line. The host side uses byte-wide push/pop strobes with empty/full flags.

## Interface
- DBIT, 8: data bits per frame.
- SB_TICK, 16: oversampling ticks in the stop bit (16 gives 1 stop bit).
- FIFO_W, 2: FIFO address width; depth is 2**FIFO_W (4).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- TIMER_FINAL_VALUE  in  11  baud tick divisor; tick period is TIMER_FINAL_VALUE+1 clocks.
- rx  in  1  serial input, idle high.
- rd_uart  in  1  pops one byte from the RX FIFO.
- r_data  out  8  head of the RX FIFO (show-ahead).
- rx_empty  out  1  RX FIFO is empty.
- w_data  in  8  byte to transmit.
- wr_uart  in  1  pushes w_data into the TX FIFO.
- tx_full  out  1  TX FIFO is full.
- tx  out  1  serial output, registered, idle high.

## Operation
- **Baud timer**
  - 11-bit counter.
  - tick = (count == TIMER_FINAL_VALUE).
  - On tick the counter goes to 0; otherwise it increments, wrapping at 2047.
  - TIMER_FINAL_VALUE=0 gives a tick on every clock.
  - If the value is lowered below the current count, the counter wraps through 2047 before matching again.
- **Receiver FSM (idle, start, data, stop)**
  - Counters: s (4-bit tick count), n (3-bit bit count), 8-bit shift register b.
  - idle: on rx==0, go to start with s=0.
  - start: on tick, if s==7 go to data with s=0, n=0; otherwise s++.
  - data: on tick, if s==15 then s=0 and b={rx,b[7:1]} (LSB first). Go to stop when n==DBIT-1, otherwise n++.
  - stop: on tick, when s==SB_TICK-1, return to idle and pulse rx_done for one clock.
  - No framing check: the stop-bit value is ignored.
- **Transmitter FSM (idle, start, data, stop)**
  - idle: tx=1. If the TX FIFO is not empty, load b from its head, pop it, go to start with s=0.
  - start: tx=0 for 16 ticks.
  - data: tx=b[0] for 16 ticks per bit, then shift right; after DBIT bits go to stop.
  - stop: tx=1 for SB_TICK ticks, then idle.
  - Back-to-back bytes are sent with no extra idle gap.
- **FIFOs**
  - RX FIFO is written by rx_done with the assembled byte. TX FIFO is written by wr_uart.
  - Write when full is ignored; the byte is dropped.
  - Read when empty is ignored.
  - Simultaneous read and write: if empty, write only; otherwise both occur and the count is unchanged.
  - Pointers wrap modulo depth.

## Timing
- Reset values:
  - tx=1, rx_empty=1, tx_full=0, r_data=0 (storage cleared).
  - Both FSMs in idle; timer count, s, n and b all 0.
- rd_uart or wr_uart sampled high at edge k updates the flags and r_data after edge k.
- A held strobe acts once per clock.
- TX start latency: wr_uart at edge k gives a non-empty TX FIFO after k. The FSM enters start at edge k+1, so tx=0 after edge k+1.
- Frame length: (16 + 16·DBIT + SB_TICK) ticks = 160 ticks at defaults. With TIMER_FINAL_VALUE=0 that is 160 clocks.
- RX sampling point: mid-bit, 8 ticks after the falling edge and then every 16 ticks. rx_empty falls one clock after rx_done.
- Reset asserted mid-frame aborts both FSMs immediately. tx returns to 1 and both FIFOs are emptied.

## Structure
- Package uart_pkg holds the FSM state enum (IDLE, START, DATA, STOP) and the defaults DBIT, SB_TICK, FIFO_W.
- The one natural sub-module is uart_fifo (parameterised width and depth), instantiated twice.
- The baud timer, RX FSM and TX FSM are inline in top_uart.

## Test plan
- **Reset:** pulse rst low mid-operation -> tx=1, rx_empty=1, tx_full=0, r_data=0 on the next cycle.
- **TX frame:** TIMER_FINAL_VALUE=0, wr_uart with w_data=0x0F for one cycle -> tx is 0 for 16 clocks, then 1,1,1,1,0,0,0,0 at 16 clocks each, then 1.
- **Loopback:** tie tx to rx, send 0xA5 with TIMER_FINAL_VALUE=3 -> rx_empty falls about 640 clocks later with r_data=0xA5. Then rd_uart for one cycle -> rx_empty=1.
- **TX FIFO full:** with the TX FSM busy, write 5 bytes in consecutive cycles -> tx_full rises. Exactly the first 4 accepted bytes plus the one in flight are transmitted, in order.
- **Divisor check:** TIMER_FINAL_VALUE=9 -> each bit lasts 160 clocks. Also check read-when-empty and write-when-full leave the FIFO state unchanged.
- **RX glitch-free idle:** hold rx=1 for 1000 clocks -> rx_empty stays 1. Then a 0x00 frame -> r_data=0x00.
